// File: rtl/rlc_pkg.sv
// Shared mode encodings, one-shot state type and the terminal-condition
// function used by both the counter datapath and its verification model.
package rlc_pkg;

  localparam logic [1:0] MODE_UPWRAP  = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_PERIOD  = 2'b10;
  localparam logic [1:0] MODE_UPCMP   = 2'b11;

  typedef enum logic {
    OS_IDLE = 1'b0,
    OS_RUN  = 1'b1
  } os_state_e;

  // Operands are zero-extended to 32 bits; width selects the all-ones pattern.
  function automatic logic rlc_terminal(
    input logic [1:0]  mode,
    input logic [31:0] q,
    input logic [31:0] rq,
    input logic        run,
    input int unsigned width
  );
    logic [31:0] ones;
    logic        term;
    ones = 32'hFFFF_FFFF >> (32 - width);
    case (mode)
      MODE_UPWRAP:  term = (q == ones);
      MODE_ONESHOT: term = run && (q == 32'd1);
      MODE_PERIOD:  term = (q == 32'd0);
      MODE_UPCMP:   term = (q == rq);
      default:      term = 1'b0;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/rlc_tc_detect.sv
// Combinational terminal lookahead and next-count selection for one counter stage.
// Load wins over reload, reload wins over a plain count step.
module rlc_tc_detect
  import rlc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       i_mode,
  input  logic             i_ce,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_dl,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_rq,
  input  logic             i_run,
  output logic             o_tc,
  output logic [WIDTH-1:0] o_q_nxt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic w_term;

  assign w_term = rlc_terminal(i_mode, 32'(i_q), 32'(i_rq), i_run, WIDTH);
  assign o_tc   = ~i_ld & i_ce & w_term;

  always_comb begin
    o_q_nxt = i_q;
    if (i_ld) begin
      o_q_nxt = i_dl;
    end else if (i_ce) begin
      case (i_mode)
        MODE_UPWRAP:  o_q_nxt = i_q + ONE;
        MODE_ONESHOT: if (i_run) o_q_nxt = i_q - ONE;
        MODE_PERIOD:  o_q_nxt = (i_q == '0) ? i_rq : (i_q - ONE);
        MODE_UPCMP:   o_q_nxt = (i_q == i_rq) ? '0 : (i_q + ONE);
        default:      o_q_nxt = i_q;
      endcase
    end
  end

endmodule

// File: rtl/rlc_counter_n.sv
// N-bit loadable/reloadable counter with four modes, one-shot FSM,
// registered terminal pulse co and same-cycle lookahead tc for cascading.
module rlc_counter_n
  import rlc_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RESET_Q = '0
) (
  input  logic             c,
  input  logic             r,
  input  logic             ce,
  input  logic             ld,
  input  logic [WIDTH-1:0] dl,
  input  logic             wr,
  input  logic [WIDTH-1:0] dr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rq,
  output logic             run,
  output logic             co,
  output logic             tc
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rq;
  logic             r_co;
  os_state_e        r_os;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc;
  logic             w_run;

  assign w_run = (r_os == OS_RUN);

  rlc_tc_detect #(
    .WIDTH (WIDTH)
  ) u_tc_detect (
    .i_mode  (mode),
    .i_ce    (ce),
    .i_ld    (ld),
    .i_dl    (dl),
    .i_q     (r_q),
    .i_rq    (r_rq),
    .i_run   (w_run),
    .o_tc    (w_tc),
    .o_q_nxt (w_q_nxt)
  );

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      r_q  <= RESET_Q;
      r_rq <= '0;
      r_co <= 1'b0;
      r_os <= OS_IDLE;
    end else begin
      r_q  <= w_q_nxt;
      r_co <= w_tc;
      if (wr) r_rq <= dr;
      // Only a load can start the one-shot; any other mode parks it idle.
      if (mode != MODE_ONESHOT) begin
        r_os <= OS_IDLE;
      end else begin
        case (r_os)
          OS_IDLE: if (ld && (dl != '0)) r_os <= OS_RUN;
          OS_RUN: begin
            if (ld)        r_os <= (dl != '0) ? OS_RUN : OS_IDLE;
            else if (w_tc) r_os <= OS_IDLE;
          end
          default: r_os <= OS_IDLE;
        endcase
      end
    end
  end

  assign q   = r_q;
  assign rq  = r_rq;
  assign run = w_run;
  assign co  = r_co;
  assign tc  = w_tc;

endmodule

// File: tb/tb_rlc_counter_n.sv
// Self-checking bench: vector table through a scoreboard queue, plus
// hand-written reset-abort and two-stage cascade sequences.
module tb_rlc_counter_n;

  typedef struct {
    logic       which;
    logic       ld;
    logic [7:0] dl;
    logic       ce;
    logic       wr;
    logic [7:0] dr;
    logic [1:0] mode;
    logic       tc;
    logic [7:0] q;
    logic [7:0] rq;
    logic       run;
    logic       co;
  } vec_t;

  logic clk = 1'b0;
  logic r   = 1'b1;

  logic       ce = 1'b0, ld = 1'b0, wr = 1'b0;
  logic [7:0] dl = '0, dr = '0;
  logic [1:0] mode = '0;
  logic [7:0] q, rq;
  logic       run, co, tc;

  logic       ce3 = 1'b0, ld3 = 1'b0, wr3 = 1'b0;
  logic [2:0] dl3 = '0, dr3 = '0;
  logic [1:0] mode3 = '0;
  logic [2:0] q3, rq3;
  logic       run3, co3, tc3;

  logic       cas_ce = 1'b0;
  logic [3:0] lo_q, lo_rq, hi_q, hi_rq;
  logic       lo_run, lo_co, lo_tc, hi_run, hi_co, hi_tc;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];
  vec_t sbq[$];
  int   cas_q[$];

  always #5 clk = ~clk;

  rlc_counter_n #(.WIDTH(8), .RESET_Q(8'h5A)) dut (
    .c(clk), .r(r), .ce(ce), .ld(ld), .dl(dl), .wr(wr), .dr(dr), .mode(mode),
    .q(q), .rq(rq), .run(run), .co(co), .tc(tc));

  rlc_counter_n #(.WIDTH(3), .RESET_Q(3'd0)) dut3 (
    .c(clk), .r(r), .ce(ce3), .ld(ld3), .dl(dl3), .wr(wr3), .dr(dr3), .mode(mode3),
    .q(q3), .rq(rq3), .run(run3), .co(co3), .tc(tc3));

  rlc_counter_n #(.WIDTH(4), .RESET_Q(4'd0)) u_lo (
    .c(clk), .r(r), .ce(cas_ce), .ld(1'b0), .dl(4'd0), .wr(1'b0), .dr(4'd0), .mode(2'b00),
    .q(lo_q), .rq(lo_rq), .run(lo_run), .co(lo_co), .tc(lo_tc));

  rlc_counter_n #(.WIDTH(4), .RESET_Q(4'd0)) u_hi (
    .c(clk), .r(r), .ce(lo_tc), .ld(1'b0), .dl(4'd0), .wr(1'b0), .dr(4'd0), .mode(2'b00),
    .q(hi_q), .rq(hi_rq), .run(hi_run), .co(hi_co), .tc(hi_tc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic wh, input logic l, input logic [7:0] d, input logic e,
                      input logic w, input logic [7:0] wd, input logic [1:0] m,
                      input logic etc, input logic [7:0] eq, input logic [7:0] erq,
                      input logic erun, input logic eco);
    vec_t v;
    v.which = wh; v.ld = l; v.dl = d; v.ce = e; v.wr = w; v.dr = wd; v.mode = m;
    v.tc = etc; v.q = eq; v.rq = erq; v.run = erun; v.co = eco;
    tbl.push_back(v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    if (!v.which) begin
      ld = v.ld; dl = v.dl; ce = v.ce; wr = v.wr; dr = v.dr; mode = v.mode;
    end else begin
      ld3 = v.ld; dl3 = v.dl[2:0]; ce3 = v.ce; wr3 = v.wr; dr3 = v.dr[2:0]; mode3 = v.mode;
    end
    #1;
    chk($sformatf("row%0d tc", idx), 32'(v.which ? tc3 : tc), 32'(v.tc));
    sbq.push_back(v);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk($sformatf("row%0d scoreboard empty", idx), 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      if (!e.which) begin
        chk($sformatf("row%0d q", idx), 32'(q), 32'(e.q));
        chk($sformatf("row%0d rq", idx), 32'(rq), 32'(e.rq));
        chk($sformatf("row%0d run", idx), 32'(run), 32'(e.run));
        chk($sformatf("row%0d co", idx), 32'(co), 32'(e.co));
      end else begin
        chk($sformatf("row%0d q3", idx), 32'(q3), 32'(e.q));
        chk($sformatf("row%0d rq3", idx), 32'(rq3), 32'(e.rq));
        chk($sformatf("row%0d run3", idx), 32'(run3), 32'(e.run));
        chk($sformatf("row%0d co3", idx), 32'(co3), 32'(e.co));
      end
    end
    ld = 1'b0; ce = 1'b0; wr = 1'b0;
    ld3 = 1'b0; ce3 = 1'b0; wr3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int c_cur;
    int c_nxt;

    // which ld dl ce wr dr mode | tc q rq run co
    // Mode 00 wrap, starting from q=5B after reset release
    addv(0,1,8'hFD,0,0,8'h00,2'b00, 0,8'hFD,8'h00,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b00, 0,8'hFE,8'h00,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b00, 0,8'hFF,8'h00,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b00, 1,8'h00,8'h00,0,1);
    addv(0,0,8'h00,1,0,8'h00,2'b00, 0,8'h01,8'h00,0,0);
    addv(0,1,8'hFF,0,0,8'h00,2'b00, 0,8'hFF,8'h00,0,0);
    addv(0,1,8'h10,1,0,8'h00,2'b00, 0,8'h10,8'h00,0,0);
    // Mode 10 periodic down
    addv(0,0,8'h00,0,1,8'h03,2'b10, 0,8'h10,8'h03,0,0);
    addv(0,1,8'h00,0,0,8'h00,2'b10, 0,8'h00,8'h03,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 1,8'h03,8'h03,0,1);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 0,8'h02,8'h03,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 0,8'h01,8'h03,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 0,8'h00,8'h03,0,0);
    addv(0,0,8'h00,1,1,8'h05,2'b10, 1,8'h03,8'h05,0,1);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 0,8'h02,8'h05,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 0,8'h01,8'h05,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 0,8'h00,8'h05,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 1,8'h05,8'h05,0,1);
    addv(0,1,8'h00,0,1,8'h00,2'b10, 0,8'h00,8'h00,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 1,8'h00,8'h00,0,1);
    addv(0,0,8'h00,1,0,8'h00,2'b10, 1,8'h00,8'h00,0,1);
    // Mode 01 one-shot
    addv(0,1,8'h02,0,0,8'h00,2'b01, 0,8'h02,8'h00,1,0);
    addv(0,0,8'h00,1,0,8'h00,2'b01, 0,8'h01,8'h00,1,0);
    addv(0,0,8'h00,1,0,8'h00,2'b01, 1,8'h00,8'h00,0,1);
    addv(0,0,8'h00,1,0,8'h00,2'b01, 0,8'h00,8'h00,0,0);
    addv(0,1,8'h05,0,0,8'h00,2'b01, 0,8'h05,8'h00,1,0);
    addv(0,1,8'h00,1,0,8'h00,2'b01, 0,8'h00,8'h00,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b01, 0,8'h00,8'h00,0,0);
    addv(0,1,8'h03,0,0,8'h00,2'b01, 0,8'h03,8'h00,1,0);
    addv(0,0,8'h00,0,0,8'h00,2'b10, 0,8'h03,8'h00,0,0);
    addv(0,0,8'h00,1,0,8'h00,2'b01, 0,8'h03,8'h00,0,0);
    addv(0,1,8'h01,0,0,8'h00,2'b01, 0,8'h01,8'h00,1,0);
    addv(0,0,8'h00,1,0,8'h00,2'b01, 1,8'h00,8'h00,0,1);
    // Mode 11 up-to-compare on the 3-bit instance
    addv(1,0,8'h00,0,1,8'h02,2'b11, 0,8'h00,8'h02,0,0);
    addv(1,1,8'h06,0,0,8'h00,2'b11, 0,8'h06,8'h02,0,0);
    addv(1,0,8'h00,1,0,8'h00,2'b11, 0,8'h07,8'h02,0,0);
    addv(1,0,8'h00,1,0,8'h00,2'b11, 0,8'h00,8'h02,0,0);
    addv(1,0,8'h00,1,0,8'h00,2'b11, 0,8'h01,8'h02,0,0);
    addv(1,0,8'h00,1,0,8'h00,2'b11, 0,8'h02,8'h02,0,0);
    addv(1,0,8'h00,1,0,8'h00,2'b11, 1,8'h00,8'h02,0,1);
    addv(1,0,8'h00,1,0,8'h00,2'b11, 0,8'h01,8'h02,0,0);
    addv(1,0,8'h00,1,0,8'h00,2'b11, 0,8'h02,8'h02,0,0);
    addv(1,1,8'h04,1,0,8'h00,2'b11, 0,8'h04,8'h02,0,0);
    addv(1,0,8'h00,0,0,8'h00,2'b11, 0,8'h04,8'h02,0,0);
    // Prime main counter at all-ones with a nonzero reload for the abort test
    addv(0,1,8'hFF,0,1,8'h77,2'b00, 0,8'hFF,8'h77,0,0);

    // Reset held while the inputs toggle randomly
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ce = 1'($urandom); ld = 1'($urandom); wr = 1'($urandom);
      dl = 8'($urandom); dr = 8'($urandom); mode = 2'($urandom);
      @(posedge clk); #1;
      chk($sformatf("reset%0d q", i), 32'(q), 32'h5A);
      chk($sformatf("reset%0d rq", i), 32'(rq), 32'h0);
      chk($sformatf("reset%0d run", i), 32'(run), 32'h0);
      chk($sformatf("reset%0d co", i), 32'(co), 32'h0);
    end
    ld = 1'b0; wr = 1'b0; ce = 1'b1; mode = 2'b00; dl = '0; dr = '0;
    r = 1'b0;
    @(posedge clk); #1;
    chk("release q", 32'(q), 32'h5B);
    chk("release co", 32'(co), 32'h0);
    ce = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Reset asserted while a terminal event is pending
    ce = 1'b1; mode = 2'b00;
    #1;
    chk("abort tc before reset", 32'(tc), 32'h1);
    #2 r = 1'b1;
    #1;
    chk("abort q", 32'(q), 32'h5A);
    chk("abort rq", 32'(rq), 32'h0);
    chk("abort co", 32'(co), 32'h0);
    @(posedge clk); #1;
    chk("abort co after edge", 32'(co), 32'h0);
    ce = 1'b0;
    r = 1'b0;
    @(posedge clk); #1;

    // Two 4-bit stages cascaded through tc
    c_cur = 0;
    for (int i = 0; i < 270; i++) begin
      cas_ce = 1'b1;
      #1;
      chk($sformatf("cas%0d hi_tc", i), 32'(hi_tc), 32'(c_cur == 8'hFF));
      cas_q.push_back(c_cur);
      @(posedge clk); #1;
      if (cas_q.size() == 0) begin
        chk("cascade scoreboard empty", 32'd1, 32'd0);
      end else begin
        c_nxt = cas_q.pop_front();
        chk($sformatf("cas%0d composite", i), 32'({hi_q, lo_q}), 32'((c_nxt + 1) & 8'hFF));
        chk($sformatf("cas%0d hi_co", i), 32'(hi_co), 32'(c_nxt == 8'hFF));
        chk($sformatf("cas%0d lo_co", i), 32'(lo_co), 32'((c_nxt & 8'h0F) == 8'h0F));
        c_cur = (c_nxt + 1) & 8'hFF;
      end
    end
    cas_ce = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
